// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction fetch front-end. It issues sequential
// word-aligned fetch requests, limits them with a credit check against a
// DEPTH-entry in-order prefetch FIFO, tags each request with its address,
// and flushes all prefetched and in-flight instructions on a redirect.
// Optional build macro: IFU_MISALIGN_CHECK_EN adds a sticky misalign_err
// output, set by any redirect whose target has nonzero bits [1:0].
module instr_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef IFU_MISALIGN_CHECK_EN
  ,output logic       misalign_err
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DepthLimit = (CW+1)'(DEPTH);

  typedef enum logic {StRun, StFlush} FetchState;

  FetchState   state_q, state_d;
  logic [31:0] fetchPc_q, fetchPc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [PW-1:0] tagRd_q, tagRd_d, tagWr_q, tagWr_d;
  logic [31:0] dataMem_q [DEPTH];
  logic [31:0] pcMem_q   [DEPTH];
  logic [31:0] tagMem_q  [DEPTH];

  logic [CW:0] creditUsed;
  logic        reqFire;
  logic        rspFire;
  logic        pushFire;
  logic        popFire;

  // Credits are shared between in-flight requests and buffered instructions,
  // so a returning response always finds a free FIFO slot.
  assign creditUsed     = {1'b0, outstanding_q} + {1'b0, count_q};
  assign imem_req_valid = !rst && (state_q == StRun) && (creditUsed < DepthLimit);
  assign imem_req_addr  = fetchPc_q;
  assign reqFire        = imem_req_valid && imem_req_ready;
  assign rspFire        = imem_rsp_valid && (outstanding_q != '0);
  assign pushFire       = rspFire && (state_q == StRun) && !redirect_valid;
  assign popFire        = instr_valid && instr_ready && !redirect_valid;

  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? dataMem_q[rdPtr_q] : '0;
  assign instr_pc    = instr_valid ? pcMem_q[rdPtr_q] : '0;

  // Next-state logic: fetch address, credit counters, FIFO pointers and the
  // RUN/FLUSH state, with redirect taking priority over everything else.
  always_comb begin
    state_d       = state_q;
    fetchPc_d     = fetchPc_q;
    outstanding_d = outstanding_q + CW'(reqFire) - CW'(rspFire);
    count_d       = count_q + CW'(pushFire) - CW'(popFire);
    rdPtr_d       = rdPtr_q + PW'(popFire);
    wrPtr_d       = wrPtr_q + PW'(pushFire);
    tagRd_d       = tagRd_q + PW'(rspFire);
    tagWr_d       = tagWr_q + PW'(reqFire);

    if (reqFire) begin
      fetchPc_d = fetchPc_q + 32'd4;
    end

    if (redirect_valid) begin
      fetchPc_d = {redirect_pc[31:2], 2'b00};
      count_d   = '0;
      rdPtr_d   = '0;
      wrPtr_d   = '0;
      state_d   = (outstanding_d != '0) ? StFlush : StRun;
    end else if ((state_q == StFlush) && (outstanding_d == '0)) begin
      state_d = StRun;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StRun;
      fetchPc_q     <= RESET_PC;
      outstanding_q <= '0;
      count_q       <= '0;
      rdPtr_q       <= '0;
      wrPtr_q       <= '0;
      tagRd_q       <= '0;
      tagWr_q       <= '0;
    end else begin
      state_q       <= state_d;
      fetchPc_q     <= fetchPc_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      rdPtr_q       <= rdPtr_d;
      wrPtr_q       <= wrPtr_d;
      tagRd_q       <= tagRd_d;
      tagWr_q       <= tagWr_d;
    end
  end

  // Storage arrays: issued-address tags and the instruction/PC FIFO.
  always_ff @(posedge clk) begin
    if (reqFire) begin
      tagMem_q[tagWr_q] <= fetchPc_q;
    end
    if (pushFire) begin
      dataMem_q[wrPtr_q] <= imem_rsp_data;
      pcMem_q[wrPtr_q]   <= tagMem_q[tagRd_q];
    end
  end

`ifdef IFU_MISALIGN_CHECK_EN
  logic misalignErr_q;

  // Sticky flag for redirects to non-word-aligned targets; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalignErr_q <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      misalignErr_q <= 1'b1;
    end
  end

  assign misalign_err = misalignErr_q;
`else
  logic unusedPcBits;
  assign unusedPcBits = ^redirect_pc[1:0];
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized scoreboard bench for instr_fetch_unit.
// A transaction-level memory model answers requests in order; responses
// that belong to an epoch older than the latest redirect are expected to
// be dropped, and the delivered stream must be gap-free sequential PCs.
module tb_instr_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef IFU_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
`ifdef IFU_MISALIGN_CHECK_EN
    ,.misalign_err  (misalign_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] memAddr;
    logic [31:0] expAddr;
    int          epoch;
    int          dueCyc;
  } PendRsp;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ExpInstr;

  PendRsp      pendQ[$];
  ExpInstr     expQ[$];
  logic [31:0] acceptLog[$];
  logic [31:0] delivLog[$];

  int nCompared = 0;
  int nMismatched = 0;
  int cyc = 0;
  int epoch = 0;
  int popCount = 0;
  int acceptCount = 0;
  int firstValidCyc = -1;
  int pushedNow = 0;
  bit captureNext = 1'b0;
  logic [31:0] firstPcAfter = 32'hDEAD_BEEF;
  logic [31:0] modelFetchPc = RESET_PC;
  logic [31:0] nextDelivPc = RESET_PC;

  int readyMode = 0;
  int irMode = 1;
  int latMin = 1;
  int latMax = 1;
  bit redirReq = 1'b0;
  logic [31:0] redirTarget = 32'h0;

  // Instruction memory contents as a pure function of the word address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // One cycle of stimulus and memory modelling, called just after a negedge.
  task automatic driveCycle();
    bit          rv, rdy, ir, redir, acc;
    logic [31:0] ra;
    int          stale, lat;
    PendRsp      p;
    ExpInstr     e;
    rv = imem_req_valid;
    ra = imem_req_addr;
    stale = 0;
    foreach (pendQ[i]) if (pendQ[i].epoch != epoch) stale++;
    if (rv) begin
      checkOutput("reqWhileFlushing", 32'(stale), 32'd0);
      checkOutput("reqCredit", 32'((pendQ.size() + expQ.size()) < DEPTH), 32'd1);
    end
    case (readyMode)
      0:       rdy = 1'b1;
      1:       rdy = cyc[0];
      2:       rdy = 1'($urandom_range(0, 1));
      default: rdy = 1'b0;
    endcase
    case (irMode)
      0:       ir = 1'b0;
      1:       ir = 1'b1;
      default: ir = 1'($urandom_range(0, 1));
    endcase
    redir = redirReq;
    redirReq = 1'b0;
    acc = rv && rdy;
    pushedNow = 0;
    if (pendQ.size() > 0 && pendQ[0].dueCyc <= cyc) begin
      p = pendQ.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data = memWord(p.memAddr);
      if (p.epoch == epoch && !redir) begin
        e.pc = p.expAddr;
        e.data = memWord(p.expAddr);
        expQ.push_back(e);
        pushedNow = 1;
      end
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data = $urandom();
    end
    if (acc) begin
      checkOutput("reqAddr", ra, modelFetchPc);
      lat = int'($urandom_range(latMax, latMin));
      p.memAddr = ra;
      p.expAddr = modelFetchPc;
      p.epoch = epoch;
      p.dueCyc = cyc + lat;
      pendQ.push_back(p);
      acceptLog.push_back(ra);
      acceptCount++;
      modelFetchPc = modelFetchPc + 32'd4;
    end
    if (redir) begin
      epoch++;
      expQ.delete();
      acceptLog.delete();
      pushedNow = 0;
      modelFetchPc = {redirTarget[31:2], 2'b00};
      nextDelivPc = modelFetchPc;
      captureNext = 1'b1;
    end
    imem_req_ready = rdy;
    instr_ready = ir;
    redirect_valid = redir;
    redirect_pc = redir ? redirTarget : $urandom();
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      cyc++;
      driveCycle();
    end
  endtask

  // Reset with output checks while held; the release cycle is cycle 1.
  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    redirReq = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1;
      checkOutput("rstReqValid", 32'(imem_req_valid), 32'd0);
      checkOutput("rstReqAddr", imem_req_addr, RESET_PC);
      checkOutput("rstInstrValid", 32'(instr_valid), 32'd0);
      checkOutput("rstInstr", instr, 32'd0);
      checkOutput("rstInstrPc", instr_pc, 32'd0);
`ifdef IFU_MISALIGN_CHECK_EN
      checkOutput("rstMisalign", 32'(misalign_err), 32'd0);
`endif
    end
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    epoch = 0;
    pendQ.delete();
    expQ.delete();
    acceptLog.delete();
    delivLog.delete();
    modelFetchPc = RESET_PC;
    nextDelivPc = RESET_PC;
    firstValidCyc = -1;
    popCount = 0;
    acceptCount = 0;
    pushedNow = 0;
    captureNext = 1'b0;
    #1;
    driveCycle();
  endtask

  // Monitor: compares the FIFO head against the scoreboard on every pop.
  initial begin : monitorProc
    ExpInstr e;
    forever begin
      @(negedge clk);
      #2;
      if (rst === 1'b0 && !redirect_valid) begin
        checkOutput("instrValid", 32'(instr_valid), 32'((expQ.size() - pushedNow) != 0));
        if (instr_valid && firstValidCyc < 0) firstValidCyc = cyc + 1;
        if (instr_valid && instr_ready && (expQ.size() > pushedNow)) begin
          e = expQ.pop_front();
          checkOutput("instrPc", instr_pc, e.pc);
          checkOutput("instrData", instr, e.data);
          checkOutput("pcSequence", instr_pc, nextDelivPc);
          nextDelivPc = nextDelivPc + 32'd4;
          delivLog.push_back(instr_pc);
          popCount++;
          if (captureNext) begin
            firstPcAfter = instr_pc;
            captureNext = 1'b0;
          end
        end
      end
    end
  end

  initial begin : mainProc
    rst = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;

    // Streaming with always-ready memory and core, latency 1.
    readyMode = 0; irMode = 1; latMin = 1; latMax = 1;
    applyReset();
    applyStimulus(30);
    checkOutput("firstValidCycle", 32'(firstValidCyc), 32'd3);
    checkOutput("streamRate", 32'(popCount >= 25), 32'd1);

    // Core stalled: credits cap requests at DEPTH, then drain in order.
    readyMode = 0; irMode = 0; latMin = 1; latMax = 1;
    applyReset();
    applyStimulus(19);
    checkOutput("stallAccepts", 32'(acceptCount), 32'd4);
    checkOutput("stallReqValid", 32'(imem_req_valid), 32'd0);
    irMode = 1;
    applyStimulus(10);
    checkOutput("drainCount", 32'(delivLog.size() >= 4), 32'd1);
    if (delivLog.size() >= 4) begin
      checkOutput("drainPc0", delivLog[0], 32'h0);
      checkOutput("drainPc1", delivLog[1], 32'h4);
      checkOutput("drainPc2", delivLog[2], 32'h8);
      checkOutput("drainPc3", delivLog[3], 32'hC);
    end

    // Redirect to 0x100 with two responses in flight.
    readyMode = 0; irMode = 1; latMin = 3; latMax = 3;
    applyReset();
    applyStimulus(1);
    readyMode = 3;
    redirReq = 1'b1;
    redirTarget = 32'h100;
    firstPcAfter = 32'hDEAD_BEEF;
    applyStimulus(1);
    readyMode = 0;
    applyStimulus(1);
    checkOutput("flushNoReq", 32'(imem_req_valid), 32'd0);
    applyStimulus(20);
    checkOutput("redirAccepts", 32'(acceptLog.size() > 0), 32'd1);
    if (acceptLog.size() > 0) checkOutput("redirFirstAddr", acceptLog[0], 32'h100);
    checkOutput("redirFirstPc", firstPcAfter, 32'h100);

    // Randomized traffic: toggling then random ready, latency 1-3, redirects.
    readyMode = 1; irMode = 2; latMin = 1; latMax = 3;
    applyReset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) readyMode = 2;
      if ($urandom_range(0, 39) == 0) begin
        redirReq = 1'b1;
        redirTarget = $urandom() & 32'h0000_3FFF;
      end
      applyStimulus(1);
    end
    checkOutput("randomProgress", 32'(popCount > 300), 32'd1);

    // Fetch address wraps from 0xFFFF_FFFC to 0.
    readyMode = 0; irMode = 1; latMin = 1; latMax = 2;
    applyReset();
    applyStimulus(3);
    redirReq = 1'b1;
    redirTarget = 32'hFFFF_FFF8;
    applyStimulus(15);
    checkOutput("wrapAccepts", 32'(acceptLog.size() >= 3), 32'd1);
    if (acceptLog.size() >= 3) begin
      checkOutput("wrapAddr0", acceptLog[0], 32'hFFFF_FFF8);
      checkOutput("wrapAddr1", acceptLog[1], 32'hFFFF_FFFC);
      checkOutput("wrapAddr2", acceptLog[2], 32'h0000_0000);
    end

    // Misaligned redirect target is fetched word-aligned.
    readyMode = 0; irMode = 1; latMin = 1; latMax = 1;
    applyReset();
    applyStimulus(4);
    redirReq = 1'b1;
    redirTarget = 32'h202;
    firstPcAfter = 32'hDEAD_BEEF;
    applyStimulus(12);
    checkOutput("alignAccepts", 32'(acceptLog.size() > 0), 32'd1);
    if (acceptLog.size() > 0) checkOutput("alignFirstAddr", acceptLog[0], 32'h200);
    checkOutput("alignFirstPc", firstPcAfter, 32'h200);
`ifdef IFU_MISALIGN_CHECK_EN
    checkOutput("misalignSet", 32'(misalign_err), 32'd1);
    applyStimulus(5);
    checkOutput("misalignSticky", 32'(misalign_err), 32'd1);
`endif
    applyReset();
    applyStimulus(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
